// File: rtl/mdio_pkg.sv
// MDIO Clause-22 PHY responder: shared states, opcodes and field sizes.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN (see mdio_phy_responder).
package mdio_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int OP_W     = 2;
  localparam int PRE_LEN  = 32;
  localparam int SKIP_LEN = 18;

  localparam logic [OP_W-1:0] OP_RD  = 2'b10;
  localparam logic [OP_W-1:0] OP_WR  = 2'b01;
  localparam logic [1:0]      ST_PAT = 2'b01;

  localparam logic [ADDR_W-1:0] REG_CTRL = 5'd0;
  localparam logic [ADDR_W-1:0] REG_ID1  = 5'd2;
  localparam logic [ADDR_W-1:0] REG_ID2  = 5'd3;

  typedef enum logic [3:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA_RD,
    DATA_WR,
    SKIP
  } state_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// MDC/MDIO 2-flop synchronisers and one-CLK MDC rising-edge pulse.
// MDIO is delayed alongside MDC so both are sampled at the same instant.
module mdio_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_line,
  output logic mdc_rise,
  output logic mdio_bit
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_q  <= '0;
      mdio_q <= '0;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio_line};
    end
  end

  assign mdc_rise = mdc_q[1] & ~mdc_q[2];
  assign mdio_bit = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder with a 32x16 register file.
// MDIO_PREAMBLE_SUPPRESS_EN: accept ST after a single preamble one.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd0,
  parameter logic [DATA_W-1:0] PHY_ID1  = 16'h0141,
  parameter logic [DATA_W-1:0] PHY_ID2  = 16'h0CC2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MDC,
  input  logic              MDIO_I,
  output logic              MDIO_O,
  output logic              MDIO_T,
  output logic              reg_wr_valid,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data
);

  state_t              state;
  logic [5:0]          pre_cnt;
  logic [4:0]          bit_cnt;
  logic [OP_W-1:0]     op;
  logic [ADDR_W-1:0]   phy_sh;
  logic [ADDR_W-1:0]   reg_sh;
  logic [DATA_W-1:0]   data_sh;
  logic [DATA_W-1:0]   regs [32];
  logic                mdc_rise;
  logic                bit_in;
  logic                pre_ok;
  logic [ADDR_W-1:0]   regad;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   wr_word;
  logic [OP_W-1:0]     op_full;

  mdio_sync_edge u_sync (
    .clk       (CLK),
    .reset     (RESET),
    .mdc       (MDC),
    .mdio_line (MDIO_I),
    .mdc_rise  (mdc_rise),
    .mdio_bit  (bit_in)
  );

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (pre_cnt != 6'd0);
`else
  assign pre_ok = (pre_cnt == 6'(PRE_LEN));
`endif

  assign regad   = {reg_sh[3:0], bit_in};
  assign wr_word = {data_sh[14:0], bit_in};
  assign op_full = {op[0], bit_in};

  always_comb begin
    rd_word = regs[regad];
    unique case (1'b1)
      regad == REG_ID1: rd_word = PHY_ID1;
      regad == REG_ID2: rd_word = PHY_ID2;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    reg_wr_valid <= 1'b0;
    if (RESET) begin
      state        <= IDLE;
      pre_cnt      <= '0;
      bit_cnt      <= '0;
      op           <= '0;
      phy_sh       <= '0;
      reg_sh       <= '0;
      data_sh      <= '0;
      MDIO_T       <= 1'b1;
      MDIO_O       <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (mdc_rise) begin
      unique case (state)
        IDLE: begin
          if (bit_in) begin
            if (pre_cnt != 6'(PRE_LEN)) pre_cnt <= pre_cnt + 6'd1;
          end else begin
            if (pre_ok) state <= ST;
            pre_cnt <= '0;
          end
        end
        ST: begin
          state   <= (bit_in == ST_PAT[0]) ? OP : IDLE;
          bit_cnt <= '0;
        end
        OP: begin
          op      <= op_full;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt <= '0;
            if (op_full == OP_RD || op_full == OP_WR) state <= PHYAD;
            else state <= SKIP;
          end
        end
        PHYAD: begin
          phy_sh  <= {phy_sh[3:0], bit_in};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt <= '0;
            state   <= REGAD;
          end
        end
        REGAD: begin
          reg_sh  <= regad;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt <= '0;
            // snapshot now so a concurrent write cannot alter the reply
            data_sh <= rd_word;
            state   <= (phy_sh == PHY_ADDR) ? TA : SKIP;
          end
        end
        TA: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd0) begin
            if (op == OP_RD) begin
              MDIO_T <= 1'b0;
              MDIO_O <= 1'b0;
            end
          end else begin
            bit_cnt <= '0;
            if (op == OP_RD) begin
              MDIO_O  <= data_sh[15];
              data_sh <= {data_sh[14:0], 1'b0};
              state   <= DATA_RD;
            end else begin
              state   <= DATA_WR;
            end
          end
        end
        DATA_RD: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            MDIO_T <= 1'b1;
            MDIO_O <= 1'b0;
            state  <= IDLE;
          end else begin
            MDIO_O  <= data_sh[15];
            data_sh <= {data_sh[14:0], 1'b0};
          end
        end
        DATA_WR: begin
          data_sh <= wr_word;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            reg_wr_valid <= 1'b1;
            reg_wr_addr  <= reg_sh;
            reg_wr_data  <= wr_word;
            state        <= IDLE;
            if (reg_sh == REG_CTRL)
              regs[reg_sh] <= {1'b0, wr_word[14:0]};
            else if (reg_sh != REG_ID1 && reg_sh != REG_ID2)
              regs[reg_sh] <= wr_word;
          end
        end
        SKIP: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'(SKIP_LEN - 1)) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed MDIO station-manager bench with a register/frame-level model.
// Honours MDIO_PREAMBLE_SUPPRESS_EN when the RTL is built with it.
module tb_mdio_phy_responder;

  localparam logic [4:0] PA = 5'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdc = 1'b0;
  logic        st_drv = 1'b0;
  logic        st_val = 1'b1;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model [32];
  logic [20:0] exp_wr [$];
  logic [20:0] w;
  logic        win = 1'b0;
  logic        exp_t = 1'b1;
  logic        exp_o = 1'b0;
  string       win_name = "";
  logic [15:0] rd;

  assign mdio_i = st_drv ? st_val : (mdio_t ? 1'b1 : mdio_o);

  always #5 clk = ~clk;

  mdio_phy_responder #(.PHY_ADDR(PA)) dut (
    .CLK          (clk),
    .RESET        (reset),
    .MDC          (mdc),
    .MDIO_I       (mdio_i),
    .MDIO_O       (mdio_o),
    .MDIO_T       (mdio_t),
    .reg_wr_valid (wr_valid),
    .reg_wr_addr  (wr_addr),
    .reg_wr_data  (wr_data)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (win) begin
      check({win_name, " mdio_t"}, {31'd0, mdio_t}, {31'd0, exp_t});
      if (!exp_t) check({win_name, " mdio_o"}, {31'd0, mdio_o}, {31'd0, exp_o});
    end
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        check("unexpected reg_wr_valid", {31'd0, wr_valid}, 32'd0);
      end else begin
        w = exp_wr.pop_front();
        check("reg_wr_addr", {27'd0, wr_addr}, {27'd0, w[20:16]});
        check("reg_wr_data", {16'd0, wr_data}, {16'd0, w[15:0]});
      end
    end
  end

  function automatic logic [15:0] model_rd(input logic [4:0] a);
    if (a == 5'd2) return 16'h0141;
    if (a == 5'd3) return 16'h0CC2;
    return model[a];
  endfunction

  function automatic bit pre_ok(input int n);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    return n >= 1;
`else
    return n >= 32;
`endif
  endfunction

  // one MDC period: station changes MDIO on the fall, samples before the rise
  task automatic mdc_bit(input logic drv, input logic val, input logic et,
                         input logic eo, input string nm, output logic smp);
    @(negedge clk);
    mdc = 1'b0;
    st_drv = drv;
    st_val = val;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    exp_t = et;
    exp_o = eo;
    win_name = nm;
    win = 1'b1;
    @(negedge clk);
    #1;
    win = 1'b0;
    smp = mdio_i;
    mdc = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic frame(input int pre, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input int abort_k,
                       output logic [15:0] data);
    logic [31:0] bits;
    logic [15:0] exp_d;
    logic        hit;
    logic        is_rd;
    logic        s;
    bits  = {2'b01, op, pa, ra, 2'b10, wd};
    is_rd = (op == 2'b10);
    hit   = (pa == PA) && pre_ok(pre) && (op == 2'b10 || op == 2'b01);
    exp_d = model_rd(ra);
    data  = '0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, 1'b1, 1'b0, "preamble", s);
    for (int k = 0; k < 32; k++) begin
      logic drv;
      logic et;
      logic eo;
      drv = !(is_rd && k >= 14);
      et  = !(hit && is_rd && k >= 15);
      eo  = (k >= 16) ? exp_d[31-k] : 1'b0;
      if (k == 31 && hit && !is_rd) begin
        exp_wr.push_back({ra, wd});
        if (ra == 5'd0) model[ra] = {1'b0, wd[14:0]};
        else if (ra != 5'd2 && ra != 5'd3) model[ra] = wd;
      end
      mdc_bit(drv, bits[31-k], et, eo, $sformatf("frame bit %0d", k), s);
      if (k >= 16) data[31-k] = s;
      if (k == abort_k) begin
        check("drive before reset", {31'd0, mdio_t}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mdio_t after reset", {31'd0, mdio_t}, 32'd1);
        check("mdio_o after reset", {31'd0, mdio_o}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        return;
      end
    end
    check("write pulses outstanding", exp_wr.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    check("reset mdio_t", {31'd0, mdio_t}, 32'd1);
    check("reset mdio_o", {31'd0, mdio_o}, 32'd0);
    check("reset wr_valid", {31'd0, wr_valid}, 32'd0);
    check("reset wr_addr", {27'd0, wr_addr}, 32'd0);
    check("reset wr_data", {16'd0, wr_data}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    frame(32, 2'b01, PA, 5'd5, 16'hA5C3, -1, rd);
    frame(32, 2'b10, PA, 5'd5, 16'h0000, -1, rd);
    check("read reg5", {16'd0, rd}, 32'h0000_A5C3);

    frame(32, 2'b10, PA, 5'd2, 16'h0000, -1, rd);
    check("read id1", {16'd0, rd}, 32'h0000_0141);
    frame(32, 2'b10, PA, 5'd3, 16'h0000, -1, rd);
    check("read id2", {16'd0, rd}, 32'h0000_0CC2);
    frame(32, 2'b01, PA, 5'd2, 16'hFFFF, -1, rd);
    frame(32, 2'b10, PA, 5'd2, 16'h0000, -1, rd);
    check("read id1 after write", {16'd0, rd}, 32'h0000_0141);

    frame(32, 2'b01, PA, 5'd0, 16'h8140, -1, rd);
    frame(32, 2'b10, PA, 5'd0, 16'h0000, -1, rd);
    check("read reg0 self-clear", {16'd0, rd}, 32'h0000_0140);

    frame(32, 2'b01, 5'd7, 5'd5, 16'h1234, -1, rd);
    frame(32, 2'b10, 5'd7, 5'd5, 16'h0000, -1, rd);
    check("foreign phy read floats", {16'd0, rd}, 32'h0000_FFFF);
    frame(32, 2'b10, PA, 5'd5, 16'h0000, -1, rd);
    check("reg5 after foreign write", {16'd0, rd}, 32'h0000_A5C3);

    frame(31, 2'b10, PA, 5'd3, 16'h0000, -1, rd);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("short preamble read", {16'd0, rd}, 32'h0000_0CC2);
`else
    check("short preamble read", {16'd0, rd}, 32'h0000_FFFF);
`endif

    frame(32, 2'b10, PA, 5'd5, 16'h0000, 23, rd);
    frame(32, 2'b10, PA, 5'd5, 16'h0000, -1, rd);
    check("reg5 after reset", {16'd0, rd}, 32'h0000_0000);

    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
